// File: rtl/avn_sram_ctrl_pkg.sv
// rtl/avn_sram_ctrl_pkg.sv - shared Avalon request/response types and SRAM bus constants
package avn_sram_ctrl_pkg;

   localparam int SRAM_DATA_W = 16;
   localparam int AVN_ADDR_W  = 32;
   localparam int AVN_DATA_W  = 32;
   localparam int AVN_BE_W    = AVN_DATA_W / 8;

   typedef struct packed {
      logic [AVN_ADDR_W-1:0] address;
      logic                  read;
      logic                  write;
      logic [AVN_DATA_W-1:0] writedata;
      logic [AVN_BE_W-1:0]   byte_enable;
   } avalon_req_t;

   typedef struct packed {
      logic                  waitrequest;
      logic [AVN_DATA_W-1:0] readdata;
   } avalon_resp_t;

endpackage

// File: rtl/avn_sram_ctrl.sv
// rtl/avn_sram_ctrl.sv - Avalon responder for a 16-bit async SRAM, 32-bit word as LO then HI half; optional SRAM_HALF_SKIP_EN
module avn_sram_ctrl
   import avn_sram_ctrl_pkg::*;
#(
   parameter int SRAM_ADDR_W = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  avalon_req_t            core_avn_req,
   output avalon_resp_t           core_avn_resp,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_dq_o,
   input  logic [SRAM_DATA_W-1:0] sram_dq_i,
   output logic                   sram_dq_oe,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n,
   output logic                   sram_ub_n,
   output logic                   sram_lb_n
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2
   } state_e;

   localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   is_wr_q, is_wr_d;
   logic [SRAM_ADDR_W-2:0] waddr_q, waddr_d;
   logic [AVN_DATA_W-1:0]  wdata_q, wdata_d;
   logic [AVN_BE_W-1:0]    be_q, be_d;
   logic [SRAM_DATA_W-1:0] lo_q, lo_d;
   logic [AVN_DATA_W-1:0]  rdata_q, rdata_d;

   logic req_any;
   logic cnt_last;
   logic wait_req;
   logic active;
   logic in_hi;
   logic unused_addr_bits;

   assign req_any  = core_avn_req.read | core_avn_req.write;
   assign cnt_last = (cnt_q == CNT_LAST);

   // Only the word address inside the SRAM window matters; the rest is ignored.
   assign unused_addr_bits = ^{core_avn_req.address[AVN_ADDR_W-1:SRAM_ADDR_W+1],
                               core_avn_req.address[1:0]};

   // Next-state: sequence LO/HI halves, capture read halves, decide the accept cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 4'd1;
      is_wr_d  = is_wr_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      lo_d     = lo_q;
      rdata_d  = rdata_q;
      wait_req = req_any;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (req_any) begin
               // Read wins when both are asserted; the request is latched so strobes
               // never depend combinationally on the initiator.
               is_wr_d = core_avn_req.write & ~core_avn_req.read;
               waddr_d = core_avn_req.address[SRAM_ADDR_W:2];
               wdata_d = core_avn_req.writedata;
               be_d    = core_avn_req.byte_enable;
               state_d = ST_LO;
`ifdef SRAM_HALF_SKIP_EN
               if (core_avn_req.write && !core_avn_req.read) begin
                  if (core_avn_req.byte_enable == '0) begin
                     state_d  = ST_IDLE;
                     wait_req = 1'b0;
                  end else if (core_avn_req.byte_enable[1:0] == 2'b00) begin
                     state_d = ST_HI;
                  end
               end
`endif
            end
         end
         ST_LO: begin
            if (cnt_last) begin
               cnt_d   = '0;
               lo_d    = sram_dq_i;
               state_d = ST_HI;
`ifdef SRAM_HALF_SKIP_EN
               if (is_wr_q && be_q[3:2] == 2'b00) begin
                  state_d  = ST_IDLE;
                  wait_req = 1'b0;
               end
`endif
            end
         end
         ST_HI: begin
            if (cnt_last) begin
               cnt_d    = '0;
               state_d  = ST_IDLE;
               wait_req = 1'b0;
               if (!is_wr_q) begin
                  rdata_d = {sram_dq_i, lo_q};
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         is_wr_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         lo_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         is_wr_q <= is_wr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         lo_q    <= lo_d;
         rdata_q <= rdata_d;
      end
   end

   // SRAM strobes decoded from registered state only.
   always_comb begin
      active     = (state_q != ST_IDLE);
      in_hi      = (state_q == ST_HI);
      sram_ce_n  = ~active;
      sram_oe_n  = ~(active & ~is_wr_q);
      sram_we_n  = ~(active & is_wr_q);
      sram_dq_oe = active & is_wr_q;
      sram_addr  = {waddr_q, in_hi};
      sram_dq_o  = in_hi ? wdata_q[AVN_DATA_W-1:SRAM_DATA_W] : wdata_q[SRAM_DATA_W-1:0];
      sram_lb_n  = 1'b1;
      sram_ub_n  = 1'b1;
      if (active) begin
         if (is_wr_q) begin
            sram_lb_n = in_hi ? ~be_q[2] : ~be_q[0];
            sram_ub_n = in_hi ? ~be_q[3] : ~be_q[1];
         end else begin
            sram_lb_n = 1'b0;
            sram_ub_n = 1'b0;
         end
      end
   end

   assign core_avn_resp.waitrequest = wait_req;
   assign core_avn_resp.readdata    = rdata_q;

endmodule

// File: tb/tb_avn_sram_ctrl.sv
// tb/tb_avn_sram_ctrl.sv - randomized self-checking bench for avn_sram_ctrl, DUT d has WAIT_CYCLES=d
module tb_avn_sram_ctrl;
   import avn_sram_ctrl_pkg::*;

   localparam int AW   = 8;
   localparam int NH   = 1 << AW;
   localparam int NW   = NH / 2;
   localparam int TMAX = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   avalon_req_t  req  [2];
   avalon_resp_t resp [2];
   logic [AW-1:0] s_addr [2];
   logic [15:0]   dq_o   [2];
   logic [15:0]   dq_i   [2];
   logic          dq_oe  [2];
   logic          ce_n   [2];
   logic          oe_n   [2];
   logic          we_n   [2];
   logic          ub_n   [2];
   logic          lb_n   [2];

   logic [15:0] mem   [2][NH];
   logic [31:0] model [2][NW];
   logic [31:0] last_rd [2];

   logic          tr_ce  [TMAX];
   logic          tr_oe  [TMAX];
   logic          tr_we  [TMAX];
   logic          tr_lb  [TMAX];
   logic          tr_ub  [TMAX];
   logic          tr_doe [TMAX];
   logic [AW-1:0] tr_addr[TMAX];
   logic [15:0]   tr_dq  [TMAX];
   logic [31:0]   tr_rd  [TMAX];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   avn_sram_ctrl #(.SRAM_ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .core_avn_req(req[0]), .core_avn_resp(resp[0]),
      .sram_addr(s_addr[0]), .sram_dq_o(dq_o[0]), .sram_dq_i(dq_i[0]), .sram_dq_oe(dq_oe[0]),
      .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
      .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0]));

   avn_sram_ctrl #(.SRAM_ADDR_W(AW), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .core_avn_req(req[1]), .core_avn_resp(resp[1]),
      .sram_addr(s_addr[1]), .sram_dq_o(dq_o[1]), .sram_dq_i(dq_i[1]), .sram_dq_oe(dq_oe[1]),
      .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
      .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1]));

   function automatic logic [15:0] init_half(input int d, input int a);
      if (d == 0 && a == 8) return 16'hBEEF;
      if (d == 0 && a == 9) return 16'hDEAD;
      return 16'((a * 40503) ^ (d * 23130) ^ 4951);
   endfunction

   function automatic int exp_lat(input int d, input bit rd, input logic [3:0] be);
      if (rd) return 2 * (d + 1);
`ifdef SRAM_HALF_SKIP_EN
      if (be == 4'h0) return 0;
      if (be[1:0] == 2'b00 || be[3:2] == 2'b00) return d + 1;
`endif
      return 2 * (d + 1) + 0 * int'(be);
   endfunction

   // SRAM behavioural model: byte-lane writes while selected, data out only when output-enabled
   initial begin
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < NH; a++)
            mem[d][a] <= init_half(d, a);
      forever begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!ce_n[d] && !we_n[d]) begin
               if (!lb_n[d]) mem[d][s_addr[d]][7:0]  <= dq_o[d][7:0];
               if (!ub_n[d]) mem[d][s_addr[d]][15:8] <= dq_o[d][15:8];
            end
         end
      end
   end

   assign dq_i[0] = (!ce_n[0] && !oe_n[0]) ? mem[0][s_addr[0]] : 16'h0000;
   assign dq_i[1] = (!ce_n[1] && !oe_n[1]) ? mem[1][s_addr[1]] : 16'h0000;

   task automatic model_access(input int d, input bit rd, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] be,
                               output logic [31:0] exp_rd);
      int w;
      w = int'(a[AW:2]);
      exp_rd = model[d][w];
      if (!rd)
         for (int b = 0; b < 4; b++)
            if (be[b]) model[d][w][8*b +: 8] = wd[8*b +: 8];
   endtask

   // Drive one request from a low clock phase, trace per-cycle outputs until accept.
   task automatic do_access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be, input bit keep,
                            output int acc, output int acc_abs, output logic [31:0] rdat);
      req[d].address     = a;
      req[d].writedata   = wd;
      req[d].byte_enable = be;
      req[d].read        = rd;
      req[d].write       = wr;
      acc     = -1;
      acc_abs = -1;
      rdat    = '0;
      for (int c = 0; c < TMAX; c++) begin
         #1;
         tr_ce[c] = ce_n[d];  tr_oe[c] = oe_n[d];  tr_we[c] = we_n[d];
         tr_lb[c] = lb_n[d];  tr_ub[c] = ub_n[d];  tr_doe[c] = dq_oe[d];
         tr_addr[c] = s_addr[d]; tr_dq[c] = dq_o[d]; tr_rd[c] = resp[d].readdata;
         if (!resp[d].waitrequest) begin
            acc     = c;
            acc_abs = cyc;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) begin
         checks++;
         errors++;
         $display("FAIL timeout dut%0d: accept seen=none required=within %0d cycles", d, TMAX);
         req[d].read  = 1'b0;
         req[d].write = 1'b0;
         acc = 0;
         return;
      end
      @(negedge clk);
      if (!keep) begin
         req[d].read  = 1'b0;
         req[d].write = 1'b0;
      end
      #1 rdat = resp[d].readdata;
   endtask

   task automatic test_reset();
      #12;
      req[1].read = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({ce_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d], dq_oe[d]} !== 6'b111110) begin
            errors++;
            $display("FAIL reset_strobes dut%0d: got=%b want=111110", d,
                     {ce_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d], dq_oe[d]});
         end
         checks++;
         if ({s_addr[d], dq_o[d], resp[d].readdata} !== '0) begin
            errors++;
            $display("FAIL reset_data dut%0d: addr=%h dq_o=%h readdata=%h want all 0",
                     d, s_addr[d], dq_o[d], resp[d].readdata);
         end
      end
      checks++;
      if ({resp[0].waitrequest, resp[1].waitrequest} !== 2'b01) begin
         errors++;
         $display("FAIL reset_waitreq: got=%b want=01",
                  {resp[0].waitrequest, resp[1].waitrequest});
      end
      req[1].read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_read_w0();
      int acc, abs_c;
      logic [31:0] rdat, exp;
      model_access(0, 1'b1, 32'h0000_0010, '0, 4'h0, exp);
      do_access(0, 1'b1, 1'b0, 32'h0000_0010, '0, 4'h0, 1'b0, acc, abs_c, rdat);
      checks++;
      if (acc != 2 || rdat !== 32'hDEADBEEF || exp !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_w0: accept=%0d data=%h want accept=2 data=deadbeef", acc, rdat);
      end
      checks++;
      if (tr_addr[1] !== 8'd8 || tr_addr[2] !== 8'd9 || tr_oe[1] !== 1'b0 || tr_oe[2] !== 1'b0 ||
          tr_doe[1] !== 1'b0 || tr_we[1] !== 1'b1 || tr_lb[1] !== 1'b0 || tr_ub[2] !== 1'b0) begin
         errors++;
         $display("FAIL read_w0_strobes: addr=%0d/%0d oe_n=%b%b doe=%b want addr=8/9 oe_n=00 doe=0",
                  tr_addr[1], tr_addr[2], tr_oe[1], tr_oe[2], tr_doe[1]);
      end
      checks++;
      if (tr_rd[2] !== 32'h0) begin
         errors++;
         $display("FAIL read_w0_early: readdata at accept=%h want=00000000", tr_rd[2]);
      end
      last_rd[0] = 32'hDEADBEEF;
   endtask

   task automatic test_write_w1();
      int acc, abs_c, n16, n17;
      logic [31:0] rdat, exp;
      model_access(1, 1'b0, 32'h20, 32'h1234_5678, 4'hF, exp);
      do_access(1, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 1'b0, acc, abs_c, rdat);
      n16 = 0;
      n17 = 0;
      for (int c = 0; c <= acc; c++) begin
         if (!tr_we[c] && tr_doe[c] && !tr_lb[c] && !tr_ub[c] && tr_addr[c] == 8'd16 && tr_dq[c] == 16'h5678) n16++;
         if (!tr_we[c] && tr_doe[c] && !tr_lb[c] && !tr_ub[c] && tr_addr[c] == 8'd17 && tr_dq[c] == 16'h1234) n17++;
      end
      checks++;
      if (acc != 4 || n16 != 2 || n17 != 2) begin
         errors++;
         $display("FAIL write_w1: accept=%0d lo_cycles=%0d hi_cycles=%0d want 4/2/2", acc, n16, n17);
      end
      checks++;
      if (mem[1][16] !== 16'h5678 || mem[1][17] !== 16'h1234 || rdat !== last_rd[1]) begin
         errors++;
         $display("FAIL write_w1_mem: sram=%h_%h readdata=%h want 1234_5678 readdata=%h",
                  mem[1][17], mem[1][16], rdat, last_rd[1]);
      end
   endtask

   task automatic test_byte_enable();
      int acc, abs_c, want_acc;
      bit hi;
      logic [31:0] rdat, exp, wd;
      wd = $urandom;
      model_access(1, 1'b0, 32'h40, wd, 4'h4, exp);
      do_access(1, 1'b0, 1'b1, 32'h40, wd, 4'h4, 1'b0, acc, abs_c, rdat);
`ifdef SRAM_HALF_SKIP_EN
      want_acc = 2;
`else
      want_acc = 4;
`endif
      checks++;
      if (acc != want_acc) begin
         errors++;
         $display("FAIL be4_accept: accept=%0d want=%0d", acc, want_acc);
      end
      for (int c = 1; c <= acc; c++) begin
         hi = (want_acc == 2) || (c > 2);
         checks++;
         if (tr_we[c] !== 1'b0 || tr_lb[c] !== !hi || tr_ub[c] !== 1'b1 ||
             tr_addr[c] !== (hi ? 8'd33 : 8'd32)) begin
            errors++;
            $display("FAIL be4_cycle%0d: we_n=%b lb_n=%b ub_n=%b addr=%0d want 0/%b/1/%0d",
                     c, tr_we[c], tr_lb[c], tr_ub[c], tr_addr[c], !hi, hi ? 33 : 32);
         end
      end
      model_access(1, 1'b1, 32'h40, '0, 4'h0, exp);
      do_access(1, 1'b1, 1'b0, 32'h40, '0, 4'h0, 1'b0, acc, abs_c, rdat);
      checks++;
      if (rdat !== exp) begin
         errors++;
         $display("FAIL be4_readback: got=%h want=%h", rdat, exp);
      end
      last_rd[1] = exp;
   endtask

   task automatic test_rw_priority();
      int acc, abs_c, nwe;
      logic [31:0] rdat, exp, a;
      a = $urandom;
      model_access(1, 1'b1, a, '0, 4'h0, exp);
      do_access(1, 1'b1, 1'b1, a, ~exp, 4'hF, 1'b0, acc, abs_c, rdat);
      nwe = 0;
      for (int c = 0; c <= acc; c++) if (tr_we[c] !== 1'b1) nwe++;
      checks++;
      if (rdat !== exp || nwe != 0 || acc != 4) begin
         errors++;
         $display("FAIL rw_priority: data=%h we_cycles=%0d accept=%0d want %h/0/4", rdat, nwe, acc, exp);
      end
      last_rd[1] = exp;
   endtask

   task automatic test_back_to_back();
      int acc1, acc2, abs1, abs2;
      logic [31:0] r1, r2, e1, e2, a1, a2;
      for (int d = 0; d < 2; d++) begin
         a1 = $urandom;
         a2 = $urandom;
         model_access(d, 1'b1, a1, '0, 4'h0, e1);
         model_access(d, 1'b1, a2, '0, 4'h0, e2);
         do_access(d, 1'b1, 1'b0, a1, '0, 4'h0, 1'b1, acc1, abs1, r1);
         do_access(d, 1'b1, 1'b0, a2, '0, 4'h0, 1'b0, acc2, abs2, r2);
         checks++;
         if (abs2 - abs1 != 2 * (d + 1) + 1) begin
            errors++;
            $display("FAIL b2b_gap dut%0d: gap=%0d want=%0d", d, abs2 - abs1, 2 * (d + 1) + 1);
         end
         checks++;
         if (r1 !== e1 || r2 !== e2) begin
            errors++;
            $display("FAIL b2b_data dut%0d: got=%h,%h want=%h,%h", d, r1, r2, e1, e2);
         end
         last_rd[d] = e2;
      end
   endtask

   task automatic test_reset_mid_access();
      int acc, abs_c;
      logic [31:0] rdat, exp, a;
      a = $urandom;
      req[1].address = a;
      req[1].read    = 1'b1;
      req[1].write   = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ce_n[1], oe_n[1], we_n[1], ub_n[1], lb_n[1]} !== 5'b11111 ||
          resp[1].waitrequest !== 1'b1 || resp[1].readdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: strobes=%b waitreq=%b readdata=%h want 11111/1/0",
                  {ce_n[1], oe_n[1], we_n[1], ub_n[1], lb_n[1]}, resp[1].waitrequest, resp[1].readdata);
      end
      @(negedge clk);
      checks++;
      if (resp[1].waitrequest !== 1'b1 || ce_n[1] !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_hold: waitreq=%b ce_n=%b want 1/1", resp[1].waitrequest, ce_n[1]);
      end
      rst_n = 1'b1;
      req[1].read = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      @(negedge clk);
      model_access(1, 1'b1, a, '0, 4'h0, exp);
      do_access(1, 1'b1, 1'b0, a, '0, 4'h0, 1'b0, acc, abs_c, rdat);
      checks++;
      if (rdat !== exp || acc != 4) begin
         errors++;
         $display("FAIL reset_mid_next: data=%h accept=%0d want %h/4", rdat, acc, exp);
      end
      last_rd[1] = exp;
   endtask

   task automatic test_random();
      int d, op, acc, abs_c, want, nce;
      bit rd, wr;
      logic [31:0] a, wd, rdat, exp;
      logic [3:0] be;
      for (int i = 0; i < 80; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         d  = $urandom_range(0, 1);
         op = $urandom_range(0, 3);
         rd = (op != 2);
         wr = (op >= 2);
         a  = $urandom;
         wd = $urandom;
         be = 4'($urandom_range(0, 15));
         want = exp_lat(d, rd, be);
         model_access(d, rd, a, wd, be, exp);
         do_access(d, rd, wr, a, wd, be, 1'b0, acc, abs_c, rdat);
         nce = 0;
         for (int c = 0; c <= acc; c++) if (tr_ce[c] === 1'b0) nce++;
         checks++;
         if (acc != want || nce != want) begin
            errors++;
            $display("FAIL rand%0d_timing dut%0d: accept=%0d active=%0d want=%0d", i, d, acc, nce, want);
         end
         checks++;
         if (tr_rd[acc] !== last_rd[d]) begin
            errors++;
            $display("FAIL rand%0d_early dut%0d: readdata at accept=%h want=%h", i, d, tr_rd[acc], last_rd[d]);
         end
         if (rd) last_rd[d] = exp;
         checks++;
         if (rdat !== last_rd[d]) begin
            errors++;
            $display("FAIL rand%0d_data dut%0d rd=%0d: got=%h want=%h", i, d, rd, rdat, last_rd[d]);
         end
      end
   endtask

   task automatic test_memory_image();
      int bad;
      for (int d = 0; d < 2; d++) begin
         bad = 0;
         for (int w = 0; w < NW; w++)
            if ({mem[d][2*w+1], mem[d][2*w]} !== model[d][w]) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL mem_image dut%0d: mismatched words=%0d want=0", d, bad);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         req[d] = '0;
         last_rd[d] = '0;
         for (int w = 0; w < NW; w++)
            model[d][w] = {init_half(d, 2*w+1), init_half(d, 2*w)};
      end
      test_reset();
      test_read_w0();
      test_write_w1();
      test_byte_enable();
      test_rw_priority();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      test_memory_image();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/avn_sram_ctrl.md
AVN_SRAM_CTRL -- requirements
Module: avn_sram_ctrl

Interface
REQ-001 SHALL have parameter SRAM_ADDR_W, default 18, meaning SRAM half-word address width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning extra SRAM cycles per half access (0..15).
REQ-003 SHALL have ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports: core_avn_req in avalon_req_t (Avalon request from the initiator); core_avn_resp out avalon_resp_t (waitrequest, readdata).
REQ-005 SHALL have ports: sram_addr out SRAM_ADDR_W half-word address; sram_dq_o out 16 write data; sram_dq_i in 16 read data; sram_dq_oe out 1 data-bus drive enable.
REQ-006 SHALL have ports: sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, each out 1, active-low SRAM strobes.

Function
REQ-007 SHALL be an Avalon responder: a 32-bit access is performed as a LO half (sram_addr = {address[SRAM_ADDR_W:2], 0}) then a HI half ({..., 1}). Address bits above SRAM_ADDR_W are ignored.
REQ-008 SHALL have FSM states IDLE, LO, HI. Transitions:
- IDLE -> LO on read|write.
- LO -> HI when cnt == WAIT_CYCLES.
- HI -> IDLE when cnt == WAIT_CYCLES.
REQ-009 SHALL reset cnt to 0 on each state entry and increment it once per cycle within LO/HI.
REQ-010 SHALL drive waitrequest = (read|write) in IDLE and LO, and = (read|write) & (cnt != WAIT_CYCLES) in HI. The accept cycle is therefore the final HI cycle.
REQ-011 SHALL present readdata = {HI half, LO half}, valid exactly one cycle after the read accept cycle, and held until the next read accept.
REQ-012 SHALL capture the LO half from sram_dq_i on the final LO cycle, and capture the HI half together with the stored LO half into the readdata register on the accept cycle.
REQ-013 SHALL give a read latency with WAIT_CYCLES=0 of: request at cycle 0, accept at cycle 2, readdata at cycle 3. A general access occupies 2*(WAIT_CYCLES+1)+1 cycles.
REQ-014 SHALL assert sram_ce_n=0 during LO/HI, with:
- Read: sram_oe_n=0, sram_dq_oe=0.
- Write: sram_we_n=0, sram_dq_oe=1, sram_dq_o = writedata[15:0] in LO and writedata[31:16] in HI.
REQ-015 SHALL drive sram_lb_n/sram_ub_n = ~byte_enable[0]/[1] in LO and ~byte_enable[2]/[3] in HI. For reads, both are 0 regardless of byte_enable.
REQ-016 SHALL decode all SRAM strobes from registered state only; no combinational path from core_avn_req.read/write to any strobe.
REQ-017 SHALL give read priority when read and write are both asserted; the write is ignored.
REQ-018 SHALL support back-to-back requests: a request held in the cycle after an accept starts a new IDLE->LO sequence with no extra gap.
REQ-019 SHALL not abort an access in LO/HI if the request drops mid-access (illegal for the initiator); the access completes and the FSM returns to IDLE.

Reset
REQ-020 SHALL, on rst_n low and regardless of clk, set: state=IDLE; cnt=0; readdata=0; LO capture=0; all sram_*_n=1; sram_dq_oe=0; sram_addr=0; sram_dq_o=0.
REQ-021 SHALL, when reset occurs mid-access, abandon the access with no accept; waitrequest follows the IDLE rule during and after reset.

Configuration
REQ-022 SHALL, when SRAM_HALF_SKIP_EN is defined, skip halves of writes as follows:
- byte_enable[1:0]==0: IDLE -> HI directly.
- byte_enable[3:2]==0: accept on the final LO cycle, then LO -> IDLE.
- byte_enable==0: accept in IDLE with waitrequest=0 and no SRAM activity.
- Reads never skip.
REQ-023 SHALL, when SRAM_HALF_SKIP_EN is undefined, always perform both halves, with strobes per REQ-015.

Structure
REQ-024 SHALL take avalon_req_t/avalon_resp_t from the shared core package. The state enum is local to the module.
REQ-025 SHALL define SRAM_DATA_W=16 as a shared constant. No sub-module; the counter and FSM live in one module.

Verification
REQ-026 SHALL verify: WAIT_CYCLES=0, read 0x0000_0010 with SRAM holding 0xBEEF at half-address 8 and 0xDEAD at half-address 9 -> waitrequest low at cycle 2, readdata 0xDEADBEEF at cycle 3.
REQ-027 SHALL verify: WAIT_CYCLES=1, write 0x1234_5678 with byte_enable 0xF to 0x20 -> sram_we_n low for 2 cycles at half-address 16 (data 0x5678) and 2 cycles at half-address 17 (data 0x1234); accept at cycle 4.
REQ-028 SHALL verify: write with byte_enable 0x4 -> LO has lb_n=ub_n=1; HI has lb_n=0, ub_n=1. With SRAM_HALF_SKIP_EN, LO is skipped and accept comes 2 cycles earlier.
REQ-029 SHALL verify: rst_n pulsed low during HI of a read -> all strobes 1 immediately, no accept, readdata 0, next read completes normally.
REQ-030 SHALL verify: read and write both asserted -> read performed, sram_we_n stays 1.
REQ-031 SHALL verify: two back-to-back reads -> second accept exactly 2*(WAIT_CYCLES+1)+1 cycles after the first.
